line_mem_nxw: RTL and testbench
===============================

Name: line_mem_nxw

Overview:
- Parametrised successor to the fixed 32-bit x 4-word line memory.
- Generalises data width (XLEN), words per line (WORDS), line count (DEPTH) and read latency (LATENCY).
- Adds a valid/ready request/response handshake, correct byte-strobe read-modify-write merging, misalignment and range errors, and write acknowledges.
- Sits behind the core's load/store unit or fetch stage as a tightly-coupled memory at BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h0002_0000, first byte address mapped to this memory.
- XLEN, 32, data word width in bits; multiple of 8, power of two.
- WORDS, 4, words per line; power of two, >= 1.
- DEPTH, 256, number of lines; power of two.
- LATENCY, 1, cycles from request acceptance to resp_valid; range 1..4.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  32  byte address.
- req_data  in  XLEN  write data.
- req_strobe  in  XLEN/8  byte enables for writes; ignored on reads.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes the response.
- resp_data  out  XLEN  read data; 0 on writes and on errors.
- resp_error  out  1  range, misalignment or parity error.

Behaviour:
- Reset, sampled on the clk edge with rst_n = 0:
  - state = IDLE; resp_valid = 0, resp_data = 0, resp_error = 0, req_ready = 0 during reset.
  - Memory contents are not cleared.
- Address decode, with BOFF = clog2(XLEN/8) and WOFF = clog2(WORDS):
  - local = req_adr - BASE_ADDR.
  - word_sel = local[BOFF+WOFF-1:BOFF].
  - index = local[BOFF+WOFF+clog2(DEPTH)-1:BOFF+WOFF].
  - range_err = (req_adr < BASE_ADDR) || (local >= DEPTH*WORDS*XLEN/8).
  - align_err = (local[BOFF-1:0] != 0).
- Handshake:
  - A request is accepted when req_valid && req_ready.
  - One outstanding request at a time.
  - req_ready = 1 only in IDLE, with rst_n high.
- State machine:
  - IDLE: on accept, latch we, index, word_sel, data, strobe and error flags. Go to RESP if LATENCY = 1, else WAIT with cnt = LATENCY-2.
  - WAIT: decrement cnt each cycle; at cnt = 0 go to RESP.
  - RESP: resp_valid = 1; resp_* held stable until resp_ready = 1, then go to IDLE.
- Timing: resp_valid first asserts exactly LATENCY cycles after the accept edge.
- Next accept is possible no earlier than the cycle after the resp_valid && resp_ready edge.
- Memory access occurs in the accept cycle, only if no error:
  - Write: byte b of mem[index][word_sel] takes req_data byte b where req_strobe[b] = 1; other bytes keep their old value.
  - Write with strobe all zero: no change, normal ack.
  - Read: word captured into the response pipeline.
- Error: no memory read or write; resp_data = 0, resp_error = 1. The error is reported through the normal response timing, never combinationally.
- Write response: resp_data = 0, resp_error = error flag.
- Reset mid-operation (WAIT or RESP): response discarded, resp_valid low next cycle. A write already performed at accept stays written.
- req_* inputs are don't-care when req_ready = 0.

Optional Feature:
- Macro LINE_MEM_PARITY_EN.
- Defined:
  - One even-parity bit stored per byte alongside each word.
  - Writes update the parity of strobed bytes only.
  - A read with any byte parity mismatch returns the data unchanged, with resp_error = 1.
- Undefined: no parity storage; resp_error reflects only range and alignment errors.

Test Plan:
Defaults: BASE_ADDR 0x20000, XLEN 32, WORDS 4, DEPTH 256, LATENCY 2.
- Write 0x20004, data 0xDEADBEEF, strobe 4'b1111 -> resp_valid 2 cycles after accept, error 0, data 0. Then read 0x20004 -> resp_data 0xDEADBEEF, error 0.
- Then write 0x20004, data 0x11223344, strobe 4'b0101 -> read 0x20004 returns 0xDE22BE44. Read 0x20008 (adjacent word) is unaffected by the write.
- Range boundaries:
  - Read 0x1FFFC -> error 1, data 0.
  - Read 0x21000 -> error 1, data 0.
  - Read 0x20FFC after writing 0xCAFEF00D there -> data 0xCAFEF00D, error 0.
- Misaligned write 0x20006, data 0xFFFFFFFF -> error 1. Subsequent read of 0x20004 is unchanged.
- Backpressure: hold resp_ready = 0 for 5 cycles with req_valid = 1 -> resp_valid, resp_data and resp_error stable, req_ready 0, no second accept. resp_ready = 1 -> IDLE, next request accepted one cycle later.
- Reset: rst_n low for 1 cycle while in WAIT after a read accept -> resp_valid never asserts. After reset, a read returns previously written memory contents.

Source files
------------

// File: rtl/line_mem_nxw_if.sv
// Request/response bus for line_mem_nxw: valid/ready request channel with byte strobes,
// and a held-until-taken response channel.
interface line_mem_nxw_if #(
   parameter int XLEN = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [31:0]       req_adr;
   logic [XLEN-1:0]   req_data;
   logic [XLEN/8-1:0] req_strobe;
   logic              resp_valid;
   logic              resp_ready;
   logic [XLEN-1:0]   resp_data;
   logic              resp_error;

   modport master (
      output req_valid, req_we, req_adr, req_data, req_strobe, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_error
   );

   modport slave (
      input  req_valid, req_we, req_adr, req_data, req_strobe, resp_ready,
      output req_ready, resp_valid, resp_data, resp_error
   );
endinterface

// File: rtl/line_mem_nxw.sv
// Parametrised tightly-coupled line memory with byte-strobe writes and fixed read latency.
// Optional per-byte even parity is enabled by defining LINE_MEM_PARITY_EN.
//
// state | meaning
// IDLE  | ready for a request; memory accessed on accept
// WAIT  | counting down the remaining latency cycles
// RESP  | response presented, held until resp_ready
module line_mem_nxw #(
   parameter logic [31:0] BASE_ADDR = 32'h0002_0000,
   parameter int          XLEN      = 32,
   parameter int          WORDS     = 4,
   parameter int          DEPTH     = 256,
   parameter int          LATENCY   = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   line_mem_nxw_if.slave  bus
);

   localparam int          SB        = XLEN / 8;
   localparam int          BOFF      = $clog2(SB);
   localparam int          AW        = $clog2(DEPTH * WORDS);
   localparam logic [32:0] MEM_BYTES = 33'(DEPTH * WORDS * SB);
   localparam logic [1:0]  CNT_INIT  = 2'((LATENCY >= 2) ? LATENCY - 2 : 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nx;
   logic [1:0]        cnt;
   logic [XLEN-1:0]   resp_data_q;
   logic              resp_err_q;

   logic [31:0]       local_adr;
   logic              range_err;
   logic              align_err;
   logic              req_err;
   logic              accept;
   logic [AW-1:0]     addr;
   logic [XLEN-1:0]   rd_word;
   logic              par_err;

   logic [XLEN-1:0]   mem [DEPTH*WORDS];

   assign local_adr = bus.req_adr - BASE_ADDR;
   assign range_err = (bus.req_adr < BASE_ADDR) || ({1'b0, local_adr} >= MEM_BYTES);
   assign align_err = (local_adr & 32'(SB - 1)) != 32'd0;
   assign req_err   = range_err || align_err;
   assign accept    = bus.req_valid && bus.req_ready;
   // flat word address: upper bits are the line index, lower bits the word select
   assign addr      = AW'(local_adr >> BOFF);
   assign rd_word   = mem[addr];

   always_ff @(posedge clk) begin
      if (accept && !req_err && bus.req_we) begin
         for (int b = 0; b < SB; b++) begin
            if (bus.req_strobe[b]) mem[addr][8*b +: 8] <= bus.req_data[8*b +: 8];
         end
      end
   end

`ifdef LINE_MEM_PARITY_EN
   logic [SB-1:0] par [DEPTH*WORDS];

   always_ff @(posedge clk) begin
      if (accept && !req_err && bus.req_we) begin
         for (int b = 0; b < SB; b++) begin
            if (bus.req_strobe[b]) par[addr][b] <= ^bus.req_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      par_err = 1'b0;
      for (int b = 0; b < SB; b++) begin
         if ((^rd_word[8*b +: 8]) != par[addr][b]) par_err = 1'b1;
      end
   end
`else
   assign par_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt         <= '0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else if (accept) begin
         cnt         <= CNT_INIT;
         resp_err_q  <= req_err || (!bus.req_we && par_err);
         resp_data_q <= (bus.req_we || req_err) ? '0 : rd_word;
      end else if (state == WAIT && cnt != 2'd0) begin
         cnt <= cnt - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = (LATENCY == 1) ? RESP : WAIT;
         WAIT:    if (cnt == 2'd0) state_nx = RESP;
         RESP:    if (bus.resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = rst_n && (state == IDLE);
      bus.resp_valid = (state == RESP);
      bus.resp_data  = (state == RESP) ? resp_data_q : '0;
      bus.resp_error = (state == RESP) ? resp_err_q : 1'b0;
   end

endmodule

// File: tb/tb_line_mem_nxw.sv
// Self-checking bench for line_mem_nxw (BASE 0x20000, 32-bit, 4 words, 256 lines, latency 2)
// against a word-array reference model.
module tb_line_mem_nxw;

   localparam logic [31:0] BASE = 32'h0002_0000;
   localparam int          SIZE = 256 * 4 * 4;
   localparam int          LAT  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] model [0:1023];

   line_mem_nxw_if #(.XLEN(32)) bus ();

   line_mem_nxw #(
      .BASE_ADDR(BASE), .XLEN(32), .WORDS(4), .DEPTH(256), .LATENCY(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic bit exp_err(input logic [31:0] a);
      return (a < BASE) || (a >= BASE + SIZE) || (a[1:0] != 2'b00);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (!exp_err(a)) begin
         for (int b = 0; b < 4; b++) if (s[b]) model[widx(a)][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   function automatic logic [31:0] exp_data(input bit we, input logic [31:0] a);
      if (we || exp_err(a)) return 32'h0;
      return model[widx(a)];
   endfunction

   // Issues one request and waits for its response; resp_ready stays high so it is taken.
   task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rd, output logic er,
                         output int lat);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_adr    = a;
      bus.req_data   = d;
      bus.req_strobe = s;
      n = 0;
      while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
      checks++;
      if (!bus.req_ready) begin
         errors++;
         $display("FAIL accept_timeout adr=%h req_ready=%b required 1", a, bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 20) begin @(negedge clk); lat++; end
      checks++;
      if (!bus.resp_valid) begin
         errors++;
         $display("FAIL resp_timeout adr=%h resp_valid=%b required 1", a, bus.resp_valid);
      end
      rd = bus.resp_data;
      er = bus.resp_error;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_error} !== 3'b000 || bus.resp_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs ready/valid/err=%b%b%b data=%h required 000 and 0",
                  bus.req_ready, bus.resp_valid, bus.resp_error, bus.resp_data);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got=%b required 1", bus.req_ready);
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [31:0] a [5]  = '{32'h20004, 32'h20004, 32'h20008, 32'h20004, 32'h20008};
      logic [31:0] d [5]  = '{32'hDEADBEEF, 32'h0, 32'h01020304, 32'h11223344, 32'hFFFFFFFF};
      logic [3:0]  s [5]  = '{4'hF, 4'h0, 4'hF, 4'b0101, 4'h0};
      for (int i = 0; i < 5; i++) begin
         do_req(1'b1, a[i], d[i], s[i], rd, er, lat);
         model_write(a[i], d[i], s[i]);
         checks++;
         if (rd !== 32'h0 || er !== 1'b0 || lat != LAT) begin
            errors++;
            $display("FAIL write_ack[%0d] data=%h err=%b lat=%0d required 0 0 %0d", i, rd, er, lat, LAT);
         end
         for (int k = 0; k < 2; k++) begin
            logic [31:0] ra;
            ra = (k == 0) ? 32'h20004 : 32'h20008;
            do_req(1'b0, ra, 32'h0, 4'h0, rd, er, lat);
            checks++;
            if (rd !== exp_data(1'b0, ra) || er !== 1'b0 || lat != LAT) begin
               errors++;
               $display("FAIL read_back[%0d] adr=%h data=%h err=%b lat=%0d required %h 0 %0d",
                        i, ra, rd, er, lat, exp_data(1'b0, ra), LAT);
            end
         end
      end
      checks++;
      if (model[1] !== 32'hDE22BE44 || model[2] !== 32'h01020304) begin
         errors++;
         $display("FAIL model_merge w1=%h w2=%h required DE22BE44 01020304", model[1], model[2]);
      end
   endtask

   task automatic test_range();
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(1'b1, 32'h20FFC, 32'hCAFEF00D, 4'hF, rd, er, lat);
      model_write(32'h20FFC, 32'hCAFEF00D, 4'hF);
      do_req(1'b0, 32'h20FFC, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
         errors++;
         $display("FAIL range_top data=%h err=%b required cafef00d 0", rd, er);
      end
      do_req(1'b0, 32'h1FFFC, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1 || lat != LAT) begin
         errors++;
         $display("FAIL range_below data=%h err=%b lat=%0d required 0 1 %0d", rd, er, lat, LAT);
      end
      do_req(1'b0, 32'h21000, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1 || lat != LAT) begin
         errors++;
         $display("FAIL range_above data=%h err=%b lat=%0d required 0 1 %0d", rd, er, lat, LAT);
      end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(1'b1, 32'h20006, 32'hFFFFFFFF, 4'hF, rd, er, lat);
      checks++;
      if (rd !== 32'h0 || er !== 1'b1) begin
         errors++;
         $display("FAIL misaligned_write data=%h err=%b required 0 1", rd, er);
      end
      do_req(1'b0, 32'h20004, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== model[1] || er !== 1'b0) begin
         errors++;
         $display("FAIL misaligned_untouched data=%h err=%b required %h 0", rd, er, model[1]);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] hd;
      logic        he;
      logic [31:0] rd;
      logic        er;
      int          n;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_adr    = 32'h20004;
      @(negedge clk);
      bus.req_adr = 32'h20FFC;
      n = 0;
      while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
      hd = bus.resp_data;
      he = bus.resp_error;
      checks++;
      if (bus.resp_valid !== 1'b1 || hd !== model[1] || he !== 1'b0) begin
         errors++;
         $display("FAIL bp_first valid=%b data=%h err=%b required 1 %h 0", bus.resp_valid, hd, he, model[1]);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.resp_valid !== 1'b1 || bus.resp_data !== hd || bus.resp_error !== he ||
             bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold[%0d] valid=%b data=%h err=%b ready=%b required 1 %h %b 0",
                     i, bus.resp_valid, bus.resp_data, bus.resp_error, bus.req_ready, hd, he);
         end
      end
      bus.resp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release valid=%b ready=%b required 0 1", bus.resp_valid, bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      n = 1;
      while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
      rd = bus.resp_data;
      er = bus.resp_error;
      checks++;
      if (rd !== 32'hCAFEF00D || er !== 1'b0 || n != LAT) begin
         errors++;
         $display("FAIL bp_next data=%h err=%b lat=%0d required cafef00d 0 %0d", rd, er, n, LAT);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(1'b1, 32'h20010, 32'h5A5AA5A5, 4'hF, rd, er, lat);
      model_write(32'h20010, 32'h5A5AA5A5, 4'hF);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_adr   = 32'h20010;
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_ready got=%b required 0", bus.req_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_valid[%0d] got=%b required 0", i, bus.resp_valid);
         end
         @(negedge clk);
      end
      do_req(1'b0, 32'h20010, 32'h0, 4'h0, rd, er, lat);
      checks++;
      if (rd !== 32'h5A5AA5A5 || er !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_keep data=%h err=%b required 5a5aa5a5 0", rd, er);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      bit          we;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         do_req(1'b1, 32'h20100 + 32'(4 * i), d, 4'hF, rd, er, lat);
         model_write(32'h20100 + 32'(4 * i), d, 4'hF);
      end
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 9))
            0:       a = 32'h20100 + 32'($urandom_range(0, 63));
            1:       a = ($urandom_range(0, 1) == 0) ? 32'h1F000 + 32'(4 * $urandom_range(0, 1023))
                                                     : 32'h21000 + 32'(4 * $urandom_range(0, 1023));
            default: a = 32'h20100 + 32'(4 * $urandom_range(0, 15));
         endcase
         we = $urandom_range(0, 1) == 1;
         d  = $urandom;
         s  = 4'($urandom_range(0, 15));
         do_req(we, a, d, s, rd, er, lat);
         if (we) model_write(a, d, s);
         checks++;
         if (rd !== exp_data(we, a) || er !== exp_err(a) || lat != LAT) begin
            errors++;
            $display("FAIL random[%0d] we=%b adr=%h data=%h err=%b lat=%0d required %h %b %0d",
                     i, we, a, rd, er, lat, exp_data(we, a), exp_err(a), LAT);
         end
      end
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_adr    = 32'h0;
      bus.req_data   = 32'h0;
      bus.req_strobe = 4'h0;
      bus.resp_ready = 1'b1;
      test_reset();
      test_write_read();
      test_range();
      test_misaligned();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
